// File: rtl/external_memory_responder.sv
// Shares one word-organized synchronous RAM between the core and an external
// initiator: stall the core, drain its in-flight access, then serve external accesses.
module external_memory_responder #(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause,
  input  logic                  externalMemoryControl,
  input  logic [31:0]           externalAddress,
  input  logic [31:0]           externalData,
  input  logic [2:0]            externalReadMode,
  input  logic [2:0]            externalWriteMode,
  output logic [31:0]           externalDataOut,
  output logic                  externalReady,
  output logic                  externalError,
  input  logic [31:0]           coreAddress,
  input  logic [31:0]           coreData,
  input  logic [2:0]            coreReadMode,
  input  logic [2:0]            coreWriteMode,
  output logic [31:0]           coreDataOut,
  output logic                  coreStall,
  output logic [ADDR_WIDTH-3:0] ramAddress,
  output logic [31:0]           ramWriteData,
  output logic [3:0]            ramByteEnable,
  output logic                  ramWriteEnable,
  input  logic [31:0]           ramReadData
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;

  localparam logic [2:0] MODE_NONE   = 3'd0;
  localparam logic [2:0] MODE_BYTE   = 3'd1;
  localparam logic [2:0] MODE_BYTE_S = 3'd2;
  localparam logic [2:0] MODE_HALF   = 3'd3;
  localparam logic [2:0] MODE_HALF_S = 3'd4;
  localparam logic [2:0] MODE_WORD   = 3'd5;

  typedef enum logic [1:0] {
    ST_CORE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_EXTERNAL = 2'd2
  } state_e;

  // Tag travelling alongside a RAM read until its data returns.
  typedef struct packed {
    logic       valid;
    logic       ext;
    logic       err;
    logic [2:0] mode;
    logic [1:0] lo;
  } rd_tag_t;

  function automatic logic is_byte(input logic [2:0] m);
    return (m == MODE_BYTE) || (m == MODE_BYTE_S);
  endfunction

  function automatic logic is_half(input logic [2:0] m);
    return (m == MODE_HALF) || (m == MODE_HALF_S);
  endfunction

  function automatic logic is_word(input logic [2:0] m);
    return m == MODE_WORD;
  endfunction

  function automatic logic is_access(input logic [2:0] m);
    return is_byte(m) || is_half(m) || is_word(m);
  endfunction

  function automatic logic misaligned(input logic [2:0] m, input logic [1:0] lo);
    return (is_half(m) && lo[0]) || (is_word(m) && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] mask_lo(input logic [2:0] m, input logic [1:0] lo);
    logic [1:0] r;
    if (is_word(m))      r = 2'b00;
    else if (is_half(m)) r = {lo[1], 1'b0};
    else                 r = lo;
    return r;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] m, input logic [1:0] lo);
    logic [3:0] r;
    if (is_byte(m))      r = 4'b1000 >> lo;
    else if (is_half(m)) r = lo[1] ? 4'b0011 : 4'b1100;
    else if (is_word(m)) r = 4'b1111;
    else                 r = 4'b0000;
    return r;
  endfunction

  function automatic logic [31:0] write_lanes(input logic [2:0] m, input logic [31:0] d);
    logic [31:0] r;
    if (is_byte(m))      r = {4{d[7:0]}};
    else if (is_half(m)) r = {2{d[15:0]}};
    else                 r = d;
    return r;
  endfunction

  // Big-endian lane extract, right-justified, then zero/sign extended.
  function automatic logic [31:0] format_read(input logic [2:0] m, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lo[1] ? w[15:0] : w[31:16];
    case (m)
      MODE_BYTE:   r = {24'd0, b};
      MODE_BYTE_S: r = {{24{b[7]}}, b};
      MODE_HALF:   r = {16'd0, h};
      MODE_HALF_S: r = {{16{h[15]}}, h};
      MODE_WORD:   r = w;
      default:     r = 32'd0;
    endcase
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [WORD_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]          ram_wdata_q, ram_wdata_d;
  logic [3:0]           ram_be_q, ram_be_d;
  logic                 ram_we_q, ram_we_d;
  logic [31:0]          ext_dout_q, core_dout_q;
  logic                 ext_err_q, ext_err_d;
  logic                 stall_q, stall_d;
  logic                 ready_q, ready_d;
  rd_tag_t              s1_q, s1_d, s2_q;
  logic [31:0]          rd_result;

  logic ext_req, ext_rd, ext_wr, ext_oob, ext_err;
  logic core_rd, core_wr;
  logic [1:0] core_rlo, core_wlo;
  logic unused_core_hi;

  assign ext_req = externalMemoryControl && pause;
  assign ext_rd  = is_access(externalReadMode);
  assign ext_wr  = is_access(externalWriteMode);
  assign ext_oob = |externalAddress[31:ADDR_WIDTH];
  assign ext_err = (ext_rd || ext_wr) &&
                   (ext_oob || (ext_rd && ext_wr) ||
                    (ext_rd && misaligned(externalReadMode, externalAddress[1:0])) ||
                    (ext_wr && misaligned(externalWriteMode, externalAddress[1:0])));

  assign core_rd  = is_access(coreReadMode);
  assign core_wr  = is_access(coreWriteMode);
  assign core_rlo = mask_lo(coreReadMode, coreAddress[1:0]);
  assign core_wlo = mask_lo(coreWriteMode, coreAddress[1:0]);

  // Core addresses beyond the RAM simply alias.
  assign unused_core_hi = |coreAddress[31:ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_CORE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CORE:     if (ext_req) state_d = ST_DRAIN;
      ST_DRAIN:    state_d = ext_req ? ST_EXTERNAL : ST_CORE;
      ST_EXTERNAL: if (!ext_req) state_d = ST_CORE;
      default:     state_d = ST_CORE;
    endcase
  end

  // RAM source mux and read tagging; DRAIN launches nothing.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = 4'b0000;
    ram_we_d    = 1'b0;
    s1_d        = '0;
    ext_err_d   = 1'b0;
    stall_d     = (state_d != ST_CORE);
    ready_d     = (state_d == ST_EXTERNAL);
    case (state_q)
      ST_CORE: begin
        ram_addr_d = coreAddress[ADDR_WIDTH-1:2];
        if (core_wr) begin
          ram_we_d    = 1'b1;
          ram_be_d    = lane_enable(coreWriteMode, core_wlo);
          ram_wdata_d = write_lanes(coreWriteMode, coreData);
        end else if (core_rd) begin
          ram_be_d = lane_enable(coreReadMode, core_rlo);
        end
        s1_d.valid = core_rd;
        s1_d.mode  = coreReadMode;
        s1_d.lo    = core_rlo;
      end
      ST_EXTERNAL: begin
        if (ext_req && (ext_rd || ext_wr)) begin
          ext_err_d  = ext_err;
          ram_addr_d = externalAddress[ADDR_WIDTH-1:2];
          if (!ext_err && ext_wr) begin
            ram_we_d    = 1'b1;
            ram_be_d    = lane_enable(externalWriteMode, externalAddress[1:0]);
            ram_wdata_d = write_lanes(externalWriteMode, externalData);
          end else if (!ext_err) begin
            ram_be_d = lane_enable(externalReadMode, externalAddress[1:0]);
          end
          s1_d.valid = ext_rd;
          s1_d.ext   = 1'b1;
          s1_d.err   = ext_err;
          s1_d.mode  = externalReadMode;
          s1_d.lo    = externalAddress[1:0];
        end
      end
      default: ;
    endcase
  end

  assign rd_result = s2_q.err ? 32'd0 : format_read(s2_q.mode, s2_q.lo, ramReadData);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      ram_we_q    <= 1'b0;
      ext_dout_q  <= '0;
      core_dout_q <= '0;
      ext_err_q   <= 1'b0;
      stall_q     <= 1'b0;
      ready_q     <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      ram_we_q    <= ram_we_d;
      ext_err_q   <= ext_err_d;
      stall_q     <= stall_d;
      ready_q     <= ready_d;
      s1_q        <= s1_d;
      s2_q        <= s1_q;
      if (s2_q.valid) begin
        if (s2_q.ext) ext_dout_q  <= rd_result;
        else          core_dout_q <= rd_result;
      end
    end
  end

  assign ramAddress      = ram_addr_q;
  assign ramWriteData    = ram_wdata_q;
  assign ramByteEnable   = ram_be_q;
  assign ramWriteEnable  = ram_we_q;
  assign externalDataOut = ext_dout_q;
  assign coreDataOut     = core_dout_q;
  assign externalError   = ext_err_q;
  assign coreStall       = stall_q;
  assign externalReady   = ready_q;

endmodule

// File: tb/tb_external_memory_responder.sv
// Randomized bench for external_memory_responder against a byte-addressed reference memory.
module tb_external_memory_responder;

  localparam int unsigned ADDR_WIDTH = 17;
  localparam int unsigned MEM_BYTES  = 1 << ADDR_WIDTH;
  localparam logic [2:0] M_NONE = 3'd0, M_BYTE = 3'd1, M_BYTE_S = 3'd2,
                         M_HALF = 3'd3, M_HALF_S = 3'd4, M_WORD = 3'd5;

  logic        clk, rst, pause, externalMemoryControl;
  logic [31:0] externalAddress, externalData, externalDataOut;
  logic [2:0]  externalReadMode, externalWriteMode;
  logic        externalReady, externalError;
  logic [31:0] coreAddress, coreData, coreDataOut;
  logic [2:0]  coreReadMode, coreWriteMode;
  logic        coreStall;
  logic [ADDR_WIDTH-3:0] ramAddress;
  logic [31:0] ramWriteData, ramReadData;
  logic [3:0]  ramByteEnable;
  logic        ramWriteEnable;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram [0:(MEM_BYTES/4)-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];

  external_memory_responder #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .externalMemoryControl(externalMemoryControl),
    .externalAddress(externalAddress), .externalData(externalData),
    .externalReadMode(externalReadMode), .externalWriteMode(externalWriteMode),
    .externalDataOut(externalDataOut), .externalReady(externalReady),
    .externalError(externalError),
    .coreAddress(coreAddress), .coreData(coreData),
    .coreReadMode(coreReadMode), .coreWriteMode(coreWriteMode),
    .coreDataOut(coreDataOut), .coreStall(coreStall),
    .ramAddress(ramAddress), .ramWriteData(ramWriteData),
    .ramByteEnable(ramByteEnable), .ramWriteEnable(ramWriteEnable),
    .ramReadData(ramReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (ramWriteEnable) begin
      if (ramByteEnable[3]) ram[ramAddress][31:24] <= ramWriteData[31:24];
      if (ramByteEnable[2]) ram[ramAddress][23:16] <= ramWriteData[23:16];
      if (ramByteEnable[1]) ram[ramAddress][15:8]  <= ramWriteData[15:8];
      if (ramByteEnable[0]) ram[ramAddress][7:0]   <= ramWriteData[7:0];
    end
    ramReadData <= ram[ramAddress];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned msize(input logic [2:0] m);
    case (m)
      M_BYTE, M_BYTE_S: return 1;
      M_HALF, M_HALF_S: return 2;
      M_WORD:           return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] m, input logic [31:0] a);
    int unsigned sz = msize(m);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < sz; i++) v = (v << 8) | 32'(ref_mem[a + 32'(i)]);
    if ((m == M_BYTE_S || m == M_HALF_S) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  // Applies the access rules to the reference memory and predicts the responses.
  task automatic model_access(input logic [2:0] rm, input logic [2:0] wm,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic err, output logic [31:0] rd, output logic [3:0] be);
    int unsigned rs = msize(rm);
    int unsigned ws = msize(wm);
    err = (rs != 0 || ws != 0) &&
          (a >= MEM_BYTES || (rs != 0 && ws != 0) ||
           (rs != 0 && (a % rs) != 0) || (ws != 0 && (a % ws) != 0));
    rd = 32'd0;
    be = 4'b0000;
    if (!err && rs != 0) rd = model_read(rm, a);
    if (!err && ws != 0) begin
      for (int i = 0; i < ws; i++) ref_mem[a + 32'(i)] = 8'(d >> (8*(ws - 1 - i)));
      be = 4'(((1 << ws) - 1) << (4 - ws - (a % 4)));
    end
  endtask

  task automatic ext_access(input logic [2:0] rm, input logic [2:0] wm,
                            input logic [31:0] a, input logic [31:0] d);
    logic exp_err;
    logic [31:0] exp_rd;
    logic [3:0] exp_be;
    model_access(rm, wm, a, d, exp_err, exp_rd, exp_be);
    externalAddress = a;  externalData = d;
    externalReadMode = rm; externalWriteMode = wm;
    tick();
    check_eq("ext_error", 32'(externalError), 32'(exp_err));
    check_eq("ram_we", 32'(ramWriteEnable), 32'(exp_be != 4'b0000));
    if (exp_be != 4'b0000) check_eq("ram_be", 32'(ramByteEnable), 32'(exp_be));
    externalReadMode = M_NONE; externalWriteMode = M_NONE;
    tick();
    check_eq("ext_error_pulse", 32'(externalError), 32'd0);
    tick();
    if (msize(rm) != 0) check_eq("ext_rdata", externalDataOut, exp_rd);
  endtask

  task automatic core_read(input logic [2:0] m, input logic [31:0] a);
    logic [31:0] exp;
    exp = model_read(m, a - (a % msize(m)));
    coreReadMode = m; coreAddress = a;
    tick();
    coreReadMode = M_NONE;
    tick();
    tick();
    check_eq("core_rdata", coreDataOut, exp);
  endtask

  task automatic grant();
    pause = 1'b1; externalMemoryControl = 1'b1;
    tick();
    check_eq("grant_stall", 32'(coreStall), 32'd1);
    check_eq("grant_ready_early", 32'(externalReady), 32'd0);
    tick();
    check_eq("grant_ready", 32'(externalReady), 32'd1);
  endtask

  task automatic release_port();
    externalMemoryControl = 1'b0;
    tick();
    check_eq("release_stall", 32'(coreStall), 32'd0);
    check_eq("release_ready", 32'(externalReady), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ext_dout"}, externalDataOut, 32'd0);
    check_eq({tag, "_core_dout"}, coreDataOut, 32'd0);
    check_eq({tag, "_ready"}, 32'(externalReady), 32'd0);
    check_eq({tag, "_error"}, 32'(externalError), 32'd0);
    check_eq({tag, "_stall"}, 32'(coreStall), 32'd0);
    check_eq({tag, "_we"}, 32'(ramWriteEnable), 32'd0);
    check_eq({tag, "_be"}, 32'(ramByteEnable), 32'd0);
    check_eq({tag, "_addr"}, 32'(ramAddress), 32'd0);
    check_eq({tag, "_wdata"}, ramWriteData, 32'd0);
  endtask

  initial begin
    logic [2:0]  rm, wm;
    logic [31:0] a;
    for (int i = 0; i < MEM_BYTES / 4; i++) ram[i] = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
    rst = 1'b0; pause = 1'b0; externalMemoryControl = 1'b0;
    externalAddress = '0; externalData = '0;
    externalReadMode = M_NONE; externalWriteMode = M_NONE;
    coreAddress = '0; coreData = '0; coreReadMode = M_NONE; coreWriteMode = M_NONE;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Request without pause must not be granted.
    externalMemoryControl = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("nopause_stall", 32'(coreStall), 32'd0);
    check_eq("nopause_ready", 32'(externalReady), 32'd0);
    externalMemoryControl = 1'b0;
    tick();

    grant();
    ext_access(M_NONE, M_WORD, 32'h0000_0400, 32'hDEAD_BEEF);
    ext_access(M_NONE, M_WORD, 32'h0001_0400, 32'h1234_5678);
    ext_access(M_WORD, M_NONE, 32'h0000_0400, 32'h0);
    ext_access(M_WORD, M_NONE, 32'h0001_0400, 32'h0);

    ext_access(M_NONE, M_WORD, 32'h0000_0500, 32'h80FF_7F01);
    ext_access(M_BYTE,   M_NONE, 32'h0000_0500, 32'h0);
    ext_access(M_BYTE_S, M_NONE, 32'h0000_0500, 32'h0);
    ext_access(M_HALF_S, M_NONE, 32'h0000_0502, 32'h0);
    ext_access(M_HALF,   M_NONE, 32'h0000_0500, 32'h0);

    ext_access(M_NONE, M_WORD, 32'h0000_0500, 32'h1122_3344);
    ext_access(M_NONE, M_BYTE, 32'h0000_0501, 32'h0000_00AA);
    ext_access(M_WORD, M_NONE, 32'h0000_0500, 32'h0);

    ext_access(M_NONE, M_WORD, 32'h0000_0402, 32'h5555_5555);
    ext_access(M_HALF, M_NONE, 32'h0000_0401, 32'h0);
    ext_access(M_WORD, M_NONE, 32'h0002_0000, 32'h0);
    ext_access(M_NONE, M_BYTE, 32'h0002_0400, 32'h0000_0077);
    ext_access(M_WORD, M_WORD, 32'h0000_0400, 32'h6666_6666);
    ext_access(M_WORD, M_NONE, 32'h0000_0400, 32'h0);

    for (int k = 0; k < 150; k++) begin
      rm = 3'($urandom_range(0, 5));
      wm = 3'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: wm = M_NONE;
        1: rm = M_NONE;
        default: ;
      endcase
      a = 32'h600 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a = a + 32'($urandom_range(1, 3)) * 32'h0002_0000;
      ext_access(rm, wm, a, $urandom);
    end

    for (int i = 0; i < 3; i++) tick();
    release_port();

    core_read(M_WORD, 32'h0001_0400);
    core_read(M_HALF, 32'h0000_0503);
    core_read(M_BYTE_S, 32'h0000_0500);

    // Reset while a write is pending in EXTERNAL must drop it.
    grant();
    externalAddress = 32'h0000_0400; externalData = 32'hCAFE_F00D;
    externalWriteMode = M_WORD;
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    externalWriteMode = M_NONE; externalMemoryControl = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("midreset_state_stall", 32'(coreStall), 32'd0);
    grant();
    ext_access(M_WORD, M_NONE, 32'h0000_0400, 32'h0);
    release_port();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
